// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_chain_loader
//  Description : Streams bitstream words into a tile-column CCFF chain, one
//                bit per prog_clk cycle, LSB first, for exactly CHAIN_LEN
//                bits. Optional readback (macro CCFF_READBACK_EN) recirculates
//                the chain once and compares CRC-16-CCITT of written and
//                returned bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int c_IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]   c_LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef CCFF_READBACK_EN
    localparam logic [2:0] S_VERIFY = 3'd4;
`endif

    logic [2:0]         r_state;
    logic [WORD_W-1:0]  r_sreg;
    logic               r_head;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [c_IDX_W-1:0] r_word_idx;

    logic w_last_bit;
    logic w_word_end;

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
    assign w_word_end = (r_word_idx == c_LAST_IDX);

`ifdef CCFF_READBACK_EN
    logic [15:0] r_crc_wr;
    logic [15:0] r_crc_rd;
    logic        r_error;
    logic [15:0] w_crc_rd_next;

    // One serial step of CRC-16-CCITT (poly 0x1021), MSB-first feedback.
    function automatic logic [15:0] f_crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign w_crc_rd_next = f_crc_step(r_crc_rd, ccff_tail);
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
`endif

    // Sequencer: word handshake, serialisation, bit counting and (optionally) readback.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_head     <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_idx <= '0;
`ifdef CCFF_READBACK_EN
            r_crc_wr   <= 16'hFFFF;
            r_crc_rd   <= 16'hFFFF;
            r_error    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_bit_cnt <= '0;
`ifdef CCFF_READBACK_EN
                        r_error   <= 1'b0;
                        r_crc_wr  <= 16'hFFFF;
                        r_crc_rd  <= 16'hFFFF;
`endif
                    end
                end
                S_LOAD: begin
                    // Head bit is presented directly; the remainder waits in sreg.
                    if (word_valid) begin
                        r_head     <= word_data[0];
                        r_sreg     <= word_data >> 1;
                        r_word_idx <= '0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
`ifdef CCFF_READBACK_EN
                    r_crc_wr <= f_crc_step(r_crc_wr, r_head);
`endif
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                    r_word_idx <= r_word_idx + c_IDX_W'(1);
                    if (w_last_bit) begin
`ifdef CCFF_READBACK_EN
                        r_state   <= S_VERIFY;
                        r_bit_cnt <= '0;
`else
                        r_state   <= S_DONE;
`endif
                    end else if (w_word_end) begin
                        // ccff_head keeps the last bit during the bubble.
                        r_state <= S_LOAD;
                    end else begin
                        r_head <= r_sreg[0];
                        r_sreg <= r_sreg >> 1;
                    end
                end
`ifdef CCFF_READBACK_EN
                S_VERIFY: begin
                    // Track the recirculated bit so the head holds it after exit.
                    r_head    <= ccff_tail;
                    r_crc_rd  <= w_crc_rd_next;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        r_error <= (w_crc_rd_next != r_crc_wr);
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign word_ready = (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

`ifdef CCFF_READBACK_EN
    assign shift_en  = (r_state == S_SHIFT) || (r_state == S_VERIFY);
    assign ccff_head = (r_state == S_VERIFY) ? ccff_tail : r_head;
    assign error     = r_error;
`else
    assign shift_en  = (r_state == S_SHIFT);
    assign ccff_head = r_head;
    assign error     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_chain_loader
//  Description : Self-checking bench for ccff_chain_loader with a 12-bit
//                chain model (optional stuck-at-0 on bit 5) and a bit
//                scoreboard fed by the word producer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 12;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 16;
`ifdef CCFF_READBACK_EN
    localparam int EXP_SHIFTS = 2 * CHAIN_LEN;
`else
    localparam int EXP_SHIFTS = CHAIN_LEN;
`endif

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              start;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              ccff_head;
    logic              shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              error;

    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 stuck5 = 1'b0;

    int tests = 0;
    int fails = 0;

    bit exp_q[$];
    bit obs_q[$];
    bit exp_bits[CHAIN_LEN];
    int pushed;
    logic [CHAIN_LEN-1:0] exp_chain;

    int   shift_cnt = 0;
    int   done_cnt  = 0;
    int   hold_viol = 0;
    bit   have_prev = 1'b0;
    logic last_head = 1'b0;

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .CNT_W    (CNT_W)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_ready(word_ready),
        .ccff_head (ccff_head),
        .shift_en  (shift_en),
        .ccff_tail (ccff_tail),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 prog_clk = ~prog_clk;

    assign ccff_tail = chain[CHAIN_LEN-1];

    // Chain model: shifts only on shift_en, optional stuck-at-0 at bit 5.
    always @(posedge prog_clk) begin : chain_model
        logic [CHAIN_LEN-1:0] nx;
        if (shift_en === 1'b1) begin
            nx = {chain[CHAIN_LEN-2:0], ccff_head};
            if (stuck5) nx[5] = 1'b0;
            chain <= nx;
        end
    end

    // Output monitor: records shifted bits, counts shifts/done, checks head hold.
    always @(negedge prog_clk) begin
        if (pReset === 1'b1) begin
            have_prev = 1'b0;
        end else begin
            if (shift_en === 1'b1) begin
                obs_q.push_back(ccff_head);
                shift_cnt = shift_cnt + 1;
                last_head = ccff_head;
                have_prev = 1'b1;
            end else if (busy === 1'b1 && have_prev && ccff_head !== last_head) begin
                hold_viol = hold_viol + 1;
            end
            if (done === 1'b1) done_cnt = done_cnt + 1;
        end
    end

    task automatic pulse_start();
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] data, input int stall);
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge prog_clk);
            if (word_ready === 1'b1) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL word_ready_wait: got %0b expected 1", word_ready);
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(posedge prog_clk);
            #1;
        end
        word_valid = 1'b1;
        word_data  = data;
        @(posedge prog_clk); #1 word_valid = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (pushed < CHAIN_LEN) begin
                exp_q.push_back(data[i]);
                exp_bits[pushed] = data[i];
                exp_chain[CHAIN_LEN-1-pushed] = data[i];
                pushed++;
            end
        end
        @(negedge prog_clk);
        tests++;
        if (shift_en !== 1'b1) begin
            fails++;
            $display("FAIL accept_to_shift: shift_en got %0b expected 1", shift_en);
        end
    endtask

    task automatic begin_load();
        pushed = 0;
        exp_q.delete();
        obs_q.delete();
        pulse_start();
        @(negedge prog_clk);
        tests++;
        if (word_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL start_latency: ready/busy got %0b%0b expected 11", word_ready, busy);
        end
        tests++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL error_clear: got %0b expected 0", error);
        end
    endtask

    task automatic do_load(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                           input int stall, input bit busy_start, input bit exp_error);
        int s0, d0, h0;
        bit got_done = 1'b0;
        s0 = shift_cnt; d0 = done_cnt; h0 = hold_viol;
        begin_load();
        send_word(w0, 0);
        if (busy_start) pulse_start();
        send_word(w1, stall);
        for (int n = 0; n < 200; n++) begin
            @(negedge prog_clk);
            if (done === 1'b1) begin got_done = 1'b1; break; end
        end
        tests++;
        if (!got_done) begin
            fails++;
            $display("FAIL done_timeout: done got %0b expected 1", done);
        end
        tests++;
        if (error !== exp_error) begin
            fails++;
            $display("FAIL error_at_done: got %0b expected %0b", error, exp_error);
        end
        @(negedge prog_clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL after_done: busy/done got %0b%0b expected 00", busy, done);
        end
        repeat (2) @(negedge prog_clk);
        tests++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL done_count: got %0d expected 1", done_cnt - d0);
        end
        tests++;
        if (shift_cnt - s0 != EXP_SHIFTS) begin
            fails++;
            $display("FAIL shift_count: got %0d expected %0d", shift_cnt - s0, EXP_SHIFTS);
        end
        tests++;
        if (hold_viol != h0) begin
            fails++;
            $display("FAIL head_hold: got %0d violations expected 0", hold_viol - h0);
        end
        for (int i = 0; i < CHAIN_LEN; i++) begin
            bit e, o;
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL head_bit[%0d]: got none expected %0b", i, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL head_bit[%0d]: got %0b expected %0b", i, o, e);
                end
            end
        end
`ifdef CCFF_READBACK_EN
        if (!exp_error) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                bit o;
                tests++;
                if (obs_q.size() == 0) begin
                    fails++;
                    $display("FAIL verify_bit[%0d]: got none expected %0b", i, exp_bits[i]);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== exp_bits[i]) begin
                        fails++;
                        $display("FAIL verify_bit[%0d]: got %0b expected %0b", i, o, exp_bits[i]);
                    end
                end
            end
        end
`endif
        if (!exp_error) begin
            tests++;
            if (chain !== exp_chain) begin
                fails++;
                $display("FAIL chain_content: got %03h expected %03h", chain, exp_chain);
            end
        end
    endtask

    task automatic test_reset();
        pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        tests++;
        if ({word_ready, ccff_head, shift_en, busy, done, error} !== 6'b0) begin
            fails++;
            $display("FAIL reset_values: got %06b expected 000000",
                     {word_ready, ccff_head, shift_en, busy, done, error});
        end
        @(posedge prog_clk); #1 pReset = 1'b0;
    endtask

    task automatic test_basic();
        do_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_load(8'hA5, 8'h3C, 5, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        do_load(8'hA5, 8'h3C, 0, 1'b1, 1'b0);
    endtask

    task automatic test_other_pattern();
        do_load(8'h5A, 8'hF1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        int d0;
        d0 = done_cnt;
        begin_load();
        send_word(8'hA5, 0);
        repeat (3) @(posedge prog_clk);
        #1 pReset = 1'b1;
        @(posedge prog_clk); #1 pReset = 1'b0;
        @(negedge prog_clk);
        tests++;
        if ({busy, shift_en, word_ready, done, ccff_head} !== 5'b0) begin
            fails++;
            $display("FAIL reset_mid_load: busy/shift/ready/done/head got %05b expected 00000",
                     {busy, shift_en, word_ready, done, ccff_head});
        end
        repeat (5) @(negedge prog_clk);
        tests++;
        if (done_cnt != d0) begin
            fails++;
            $display("FAIL reset_no_done: got %0d done pulses expected 0", done_cnt - d0);
        end
        do_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback_stuck();
        stuck5 = 1'b1;
        do_load(8'hA5, 8'h3C, 0, 1'b0, 1'b1);
        repeat (5) @(negedge prog_clk);
        tests++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL error_sticky: got %0b expected 1", error);
        end
        stuck5 = 1'b0;
        do_load(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_while_busy();
        test_other_pattern();
        test_reset_mid_load();
`ifdef CCFF_READBACK_EN
        test_readback_stuck();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
